// File: rtl/pattern_stream_decoder_if.sv
// Handshake bundle for pattern_stream_decoder: start/status, memory
// request/response and index output channels.
interface pattern_stream_decoder_if #(
    parameter int unsigned INDEX_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 48,
    parameter int unsigned DATA_WIDTH  = 64
) ();
    logic                   start;
    logic [ADDR_WIDTH-1:0]  start_addr;
    logic                   req;
    logic [ADDR_WIDTH-1:0]  req_addr;
    logic                   req_stall;
    logic                   push;
    logic [DATA_WIDTH-1:0]  data;
    logic                   index_push;
    logic [INDEX_WIDTH-1:0] row;
    logic [INDEX_WIDTH-1:0] col;
    logic                   index_stall;
    logic                   busy;
    logic                   done;

    // Driver side: stimulus, memory and consumer.
    modport master (
        output start, start_addr, req_stall, push, data, index_stall,
        input  req, req_addr, index_push, row, col, busy, done
    );

    // Decoder side.
    modport slave (
        input  start, start_addr, req_stall, push, data, index_stall,
        output req, req_addr, index_push, row, col, busy, done
    );
endinterface

// File: rtl/pattern_stream_decoder.sv
// Fetches a packed delta-encoded nonzero pattern from word-addressed memory
// and emits one (row, col) pair per DELTA code. Words are prefetched into a
// small buffer; request credit keeps buffered plus in-flight words within
// FIFO_DEPTH so responses never need to be refused.
module pattern_stream_decoder #(
    parameter int unsigned INDEX_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH  = 48,
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned CODE_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input logic                    clk,
    input logic                    rst,
    pattern_stream_decoder_if.slave bus
);
    localparam int unsigned CodesPerWord = DATA_WIDTH / CODE_WIDTH;
    localparam int unsigned SubW         = (CodesPerWord > 1) ? $clog2(CodesPerWord) : 1;
    localparam int unsigned PtrW         = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW         = PtrW + 1;
    localparam int unsigned PayW         = CODE_WIDTH - 2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [1:0] OpDelta  = 2'b00;
    localparam logic [1:0] OpNewRow = 2'b01;
    localparam logic [1:0] OpNop    = 2'b10;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]        count_q, count_d;   // words buffered, not fully consumed
    logic [CntW-1:0]        outst_q, outst_d;   // requests transferred, awaiting response
    logic [SubW-1:0]        sub_q, sub_d;       // code index within head word
    logic [INDEX_WIDTH-1:0] row_q, row_d;
    logic [INDEX_WIDTH-1:0] col_q, col_d;
    logic                   req_q, req_d;
    logic [ADDR_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic                   index_push_q, index_push_d;
    logic                   done_q, done_d;
    logic                   wr_en;

    logic [DATA_WIDTH-1:0]  head_word;
    logic [CODE_WIDTH-1:0]  code;
    logic [1:0]             opcode;
    logic [PayW-1:0]        payload;
    logic [INDEX_WIDTH-1:0] payload_ext;
    logic                   xfer;
    logic                   resp;
    logic                   consume;
    logic                   last_code;
    logic [CntW:0]          credit_sum;

    assign head_word   = fifo_q[rd_ptr_q];
    assign code        = CODE_WIDTH'(head_word >> (32'(sub_q) * CODE_WIDTH));
    assign opcode      = code[CODE_WIDTH-1 -: 2];
    assign payload     = code[PayW-1:0];
    // Size cast zero-extends, or truncates when rows/cols are narrower than
    // the payload; either way the result is the payload mod 2^INDEX_WIDTH.
    assign payload_ext = INDEX_WIDTH'(payload);
    assign xfer        = req_q & ~bus.req_stall;
    assign resp        = bus.push & (outst_q != '0);
    assign consume     = (state_q == StRun) & (count_q != '0) & ~bus.index_stall;
    assign last_code   = (sub_q == SubW'(CodesPerWord - 1));

    // Next-state, buffer bookkeeping, decode and request credit.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        outst_d      = outst_q + CntW'(xfer) - CntW'(resp);
        sub_d        = sub_q;
        row_d        = row_q;
        col_d        = col_q;
        req_addr_d   = xfer ? req_addr_q + ADDR_WIDTH'(1) : req_addr_q;
        index_push_d = 1'b0;
        done_d       = 1'b0;
        wr_en        = 1'b0;
        credit_sum   = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StRun;
                    row_d      = '0;
                    col_d      = '0;
                    req_addr_d = bus.start_addr;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    count_d    = '0;
                    outst_d    = '0;
                    sub_d      = '0;
                end
            end
            StRun: begin
                if (bus.push) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + PtrW'(1);
                    count_d  = count_q + CntW'(1);
                end
                if (consume) begin
                    if (opcode == OpDelta) begin
                        col_d        = col_q + payload_ext;
                        index_push_d = 1'b1;
                    end else if (opcode == OpNewRow) begin
                        row_d = row_q + payload_ext;
                        col_d = '0;
                    end else if (opcode == OpNop) begin
                        row_d = row_q;
                    end
                    if (opcode == 2'b11) begin
                        // END: everything buffered, including a word landing
                        // this cycle, is thrown away.
                        state_d = StDrain;
                        wr_en   = 1'b0;
                        count_d = '0;
                        sub_d   = '0;
                    end else if (last_code) begin
                        sub_d    = '0;
                        rd_ptr_d = rd_ptr_q + PtrW'(1);
                        count_d  = count_d - CntW'(1);
                    end else begin
                        sub_d = sub_q + SubW'(1);
                    end
                end
            end
            StDrain: begin
                if (outst_q == '0 && !bus.push) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A presented request is reserved against credit; a stalled one stays
        // within credit because the buffered+outstanding sum can only fall.
        credit_sum = {1'b0, count_d} + {1'b0, outst_d};
        req_d      = (state_d == StRun) && (credit_sum < (CntW + 1)'(FIFO_DEPTH));
    end

    // State and control registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            outst_q      <= '0;
            sub_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            req_q        <= 1'b0;
            req_addr_q   <= '0;
            index_push_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            outst_q      <= outst_d;
            sub_q        <= sub_d;
            row_q        <= row_d;
            col_q        <= col_d;
            req_q        <= req_d;
            req_addr_q   <= req_addr_d;
            index_push_q <= index_push_d;
            done_q       <= done_d;
        end
    end

    // Buffer storage; validity is tracked by count_q, so no reset needed.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_q[wr_ptr_q] <= bus.data;
        end
    end

    assign bus.req        = req_q;
    assign bus.req_addr   = req_addr_q;
    assign bus.index_push = index_push_q;
    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_pattern_stream_decoder.sv
// Bench for pattern_stream_decoder: directed and random streams, a
// random-latency memory responder and a scoreboard built from the code rules.
// A second 8-bit-index instance shares every input to check index wrap.
module tb_pattern_stream_decoder;
    localparam int unsigned IW = 32;
    localparam int unsigned AW = 48;
    localparam int unsigned DW = 64;
    localparam int unsigned CW = 16;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pattern_stream_decoder_if #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b ();
    pattern_stream_decoder_if #(.INDEX_WIDTH(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b8 ();

    pattern_stream_decoder #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                             .CODE_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(b.slave));
    pattern_stream_decoder #(.INDEX_WIDTH(8), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                             .CODE_WIDTH(CW), .FIFO_DEPTH(DEPTH)) dut8 (
        .clk(clk), .rst(rst), .bus(b8.slave));

    assign b8.start       = b.start;
    assign b8.start_addr  = b.start_addr;
    assign b8.req_stall   = b.req_stall;
    assign b8.push        = b.push;
    assign b8.data        = b.data;
    assign b8.index_stall = b.index_stall;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int push_pct = 100;
    bit rand_rs = 0, rand_is = 0, force_rs = 0, force_is = 0;

    logic [63:0] mem [logic [47:0]];
    logic [47:0] pend_q [$];
    logic [63:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] rd(input logic [47:0] a);
        return mem.exists(a) ? mem[a] : 64'h8000_8000_8000_8000;
    endfunction

    // Reference: walk words from a, apply code rules, collect expected pairs.
    task automatic build_expect(input logic [47:0] a_in);
        logic [47:0] a;
        logic [31:0] r, c;
        logic [63:0] w;
        logic [15:0] cd;
        bit fin;
        a = a_in; r = 0; c = 0; fin = 0;
        exp_q.delete();
        for (int n = 0; n < 1000 && !fin; n++) begin
            w = rd(a);
            for (int k = 0; k < 4 && !fin; k++) begin
                cd = w[k*16 +: 16];
                case (cd[15:14])
                    2'b00: begin c = c + 32'(cd[13:0]); exp_q.push_back({r, c}); end
                    2'b01: begin r = r + 32'(cd[13:0]); c = 0; end
                    2'b10: ;
                    default: fin = 1;
                endcase
            end
            a = a + 48'd1;
        end
    endtask

    task automatic gen_stream(input logic [47:0] base, input int nw);
        logic [63:0] w;
        logic [15:0] cd;
        int r;
        for (int i = 0; i < nw; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) begin
                r = $urandom_range(0, 9);
                if (r < 6) cd = {2'b00, ($urandom_range(0, 7) == 0) ? 14'h3FFF
                                                                  : 14'($urandom_range(0, 40))};
                else if (r < 8) cd = {2'b01, 14'($urandom_range(0, 5))};
                else cd = {2'b10, 14'($urandom)};
                w[k*16 +: 16] = cd;
            end
            if (i == nw - 1) begin
                r = $urandom_range(0, 3);
                w[r*16 +: 16] = {2'b11, 14'($urandom)};
            end
            mem[base + 48'(i)] = w;
        end
        for (int i = nw; i < nw + 10; i++) mem[base + 48'(i)] = {$urandom, $urandom};
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, b.req, 0);
        chk({tag, "_req_addr"}, b.req_addr, 0);
        chk({tag, "_index_push"}, b.index_push, 0);
        chk({tag, "_row"}, b.row, 0);
        chk({tag, "_col"}, b.col, 0);
        chk({tag, "_busy"}, b.busy, 0);
        chk({tag, "_done"}, b.done, 0);
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, done_cnt - d0, 1);
        repeat (3) @(negedge clk);
        chk({tag, "_pairs_left"}, exp_q.size(), 0);
        chk({tag, "_single_done"}, done_cnt - d0, 1);
    endtask

    // Memory responder and stall drivers, acting 1 time unit after negedge.
    initial begin
        b.push = 0; b.data = '0; b.req_stall = 0; b.index_stall = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                pend_q.delete();
                b.push = 0; b.req_stall = 0; b.index_stall = 0;
            end else begin
                b.req_stall   = force_rs | (rand_rs && $urandom_range(0, 3) == 0);
                b.index_stall = force_is | (rand_is && $urandom_range(0, 2) == 0);
                if (pend_q.size() > 0 && $urandom_range(0, 99) < push_pct) begin
                    b.push = 1;
                    b.data = rd(pend_q.pop_front());
                end else begin
                    b.push = 0;
                    b.data = {$urandom, $urandom};
                end
                if (b.req && !b.req_stall) pend_q.push_back(b.req_addr);
            end
        end
    end

    // Scoreboard on index pushes and done pulses.
    initial begin
        bit s_prev, s_cur;
        logic [63:0] e;
        s_prev = 0; s_cur = 0;
        forever begin
            @(posedge clk);
            s_prev = s_cur;
            s_cur  = b.index_stall;
            @(negedge clk);
            if (rst) begin
                if (b.index_push || b8.index_push) chk("push8_match", b8.index_push, b.index_push);
                if (b.index_push) begin
                    chk("stalled_push", 64'(s_prev && s_cur), 0);
                    if (exp_q.size() == 0) chk("extra_push", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("pair", {b.row, b.col}, e);
                        chk("pair8", {b8.row, b8.col}, {48'b0, e[39:32], e[7:0]});
                    end
                end
                if (b.done) begin
                    done_cnt++;
                    chk("busy_at_done", b.busy, 0);
                    chk("resp_pending_at_done", pend_q.size(), 0);
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, nw;
        logic [47:0] base;
        b.start = 0; b.start_addr = '0;
        #2 rst = 0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1;
        repeat (2) @(negedge clk);

        // Basic stream.
        mem[48'h0] = 64'hC000_0001_0002_0000;
        build_expect(48'h0);
        push_pct = 100;
        d0 = done_cnt;
        b.start = 1; b.start_addr = 48'h0;
        @(negedge clk);
        b.start = 0;
        chk("start_busy", b.busy, 1);
        chk("start_req", b.req, 1);
        chk("start_req_addr", b.req_addr, 48'h0);
        wait_done("basic", d0, 500);

        // Multi-word with prefetched garbage that must be discarded.
        mem[48'h10] = 64'h0005_4002_0001_0000;
        mem[48'h11] = 64'h8000_8000_C000_0003;
        for (int i = 'h12; i < 'h1a; i++) mem[48'(i)] = 64'h0000_0000_0000_0000;
        build_expect(48'h10);
        chk("multi_model_len", exp_q.size(), 4);
        push_pct = 50;
        d0 = done_cnt;
        b.start = 1; b.start_addr = 48'h10;
        @(negedge clk);
        b.start = 0;
        wait_done("multi", d0, 500);

        // Memory stall on the very first request.
        mem[48'h30] = 64'h0000_0003_0002_0001;
        mem[48'h31] = 64'h0000_0000_0000_C000;
        build_expect(48'h30);
        push_pct = 100;
        d0 = done_cnt;
        force_rs = 1;
        b.start = 1; b.start_addr = 48'h30;
        @(negedge clk);
        b.start = 0;
        for (int i = 0; i < 5; i++) begin
            chk("req_stall_req", b.req, 1);
            chk("req_stall_addr", b.req_addr, 48'h30);
            if (i < 4) @(negedge clk);
        end
        force_rs = 0;
        @(negedge clk);
        chk("addr_after_release", b.req_addr, 48'h31);
        wait_done("mstall", d0, 500);

        // Consumer stall while the buffer fills.
        for (int i = 0; i < 24; i++) mem[48'h100 + 48'(i)] = 64'h0001_0001_0001_0001;
        mem[48'h118] = 64'h0000_0000_0000_C000;
        build_expect(48'h100);
        d0 = done_cnt;
        b.start = 1; b.start_addr = 48'h100;
        @(negedge clk);
        b.start = 0;
        repeat (12) @(negedge clk);
        force_is = 1;
        repeat (20) @(negedge clk);
        chk("req_stops_when_full", b.req, 0);
        force_is = 0;
        wait_done("istall", d0, 1000);

        // Index wrap visible on the 8-bit instance: (0,255) then (0,1).
        mem[48'h200] = 64'h8000_C000_0002_00FF;
        build_expect(48'h200);
        d0 = done_cnt;
        b.start = 1; b.start_addr = 48'h200;
        @(negedge clk);
        b.start = 0;
        wait_done("wrap", d0, 500);

        // Random streams, random stalls and latency, spurious mid-run start.
        for (int s = 0; s < 6; s++) begin
            base = (s == 0) ? 48'hFFFF_FFFF_FFFD : 48'(32'h0001_0000 + s * 32'h100);
            nw = $urandom_range(3, 12);
            gen_stream(base, nw);
            build_expect(base);
            push_pct = $urandom_range(30, 100);
            rand_rs = 1; rand_is = 1;
            d0 = done_cnt;
            b.start = 1; b.start_addr = base;
            @(negedge clk);
            b.start = 0;
            repeat ($urandom_range(2, 8)) @(negedge clk);
            if (b.busy) begin
                b.start = 1; b.start_addr = 48'h5555;
                @(negedge clk);
                b.start = 0;
            end
            wait_done("rand", d0, 3000);
        end
        rand_rs = 0; rand_is = 0;

        // Reset abort with requests outstanding, then a clean restart.
        for (int i = 0; i < 16; i++) mem[48'h300 + 48'(i)] = 64'h0001_0001_0001_0001;
        mem[48'h310] = 64'h0000_0000_0000_C000;
        build_expect(48'h300);
        push_pct = 30;
        d0 = done_cnt;
        b.start = 1; b.start_addr = 48'h300;
        @(negedge clk);
        b.start = 0;
        repeat (6) @(negedge clk);
        #2 rst = 0;
        #1 chk_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        mem[48'h20] = 64'h0000_C000_4001_0007;
        build_expect(48'h20);
        push_pct = 100;
        d0 = done_cnt;
        b.start = 1; b.start_addr = 48'h20;
        @(negedge clk);
        b.start = 0;
        chk("restart_req_addr", b.req_addr, 48'h20);
        wait_done("restart", d0, 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pattern_stream_decoder.md
# pattern_stream_decoder

Parametrised successor to the sparse-pattern decoder. It fetches a packed, delta-encoded nonzero pattern from word-addressed memory and emits one (row, col) index pair per nonzero. Over the previous generation it adds:
- configurable index, address, data and code widths;
- a bounded prefetch buffer with outstanding-request credit;
- memory-side request stall and consumer-side index stall;
- an explicit end-of-stream code with busy/done status.

## Interface
- INDEX_WIDTH, 32, width of row/col outputs.
- ADDR_WIDTH, 48, memory word-address width.
- DATA_WIDTH, 64, memory response word width.
- CODE_WIDTH, 16, width of one pattern code. Must divide DATA_WIDTH and be at least 3.
- FIFO_DEPTH, 8, maximum accepted-but-unconsumed words. Power of two, at least 2.

- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts decode at start_addr. Ignored while busy.
- start_addr  in  ADDR_WIDTH  first word address, sampled with start.
- req  out  1  memory read request.
- req_addr  out  ADDR_WIDTH  word address of the request.
- req_stall  in  1  memory cannot accept; req and req_addr held.
- push  in  1  response valid; always accepted.
- data  in  DATA_WIDTH  response word, in request order.
- index_push  out  1  row/col valid this cycle.
- row  out  INDEX_WIDTH  current row.
- col  out  INDEX_WIDTH  current column.
- index_stall  in  1  consumer backpressure.
- busy  out  1  decode in progress.
- done  out  1  one-cycle pulse at stream completion.

## Operation
- States: IDLE, RUN, DRAIN.
  - IDLE: start moves to RUN. row, col and the word address are loaded from 0, 0 and start_addr.
  - RUN: on END code, move to DRAIN.
  - DRAIN: when no requests are outstanding and push is low, move to IDLE with done=1 for one cycle.
- busy = (state != IDLE).
- Fetch:
  - A request transfers in any cycle where req=1 and req_stall=0. The address then increments by 1, wrapping mod 2^ADDR_WIDTH.
  - Words accepted but not fully consumed must never exceed FIFO_DEPTH, so push is never refused.
  - No new requests are issued in DRAIN. Responses arriving in DRAIN are discarded.
- Code packing: each word carries DATA_WIDTH/CODE_WIDTH codes, consumed LSB-first. The top 2 bits of a code are the opcode; the low CODE_WIDTH-2 bits are the payload, zero-extended to INDEX_WIDTH.
  - 00 DELTA: col += payload, then emit (row, col). A payload of 0 is legal and emits.
  - 01 NEWROW: row += payload, col = 0. No emit.
  - 10 NOP: no effect.
  - 11 END: stop. Remaining codes and buffered words are discarded.
- Arithmetic: row and col wrap mod 2^INDEX_WIDTH.
- Throughput: one code consumed per cycle while the buffer is non-empty and index_stall=0. No code is consumed while index_stall=1.
- start during RUN or DRAIN is ignored.
- Buffer empty in RUN: decode waits. It is not an error.

## Timing
- Reset values: req=0, req_addr=0, index_push=0, row=0, col=0, busy=0, done=0. Buffer and credit are cleared. Reset mid-stream aborts immediately and no done is generated.
- start at cycle T: busy=1 and req=1 at T+1, with req_addr=start_addr.
- A response can arrive at earliest one cycle after its request transfers.
- Word arriving via push at cycle P: its first code is consumed no earlier than P+1.
- DELTA consumed at cycle C: index_push=1 at C+1, with the updated row/col.
- All outputs are registered.
- index_stall: index_push may be high in the first cycle index_stall is high. It is never high in later cycles while index_stall stays high.
- req_stall: req and req_addr are unchanged until the cycle the request transfers.
- done and busy falling occur in the same cycle.

## Test plan
- Basic stream (CODE_WIDTH=16): start_addr=0, mem[0]=0xC000_0001_0002_0000 -> pushes (0,0), (0,2), (0,3); then done. The first req is at address 0.
- Multi-word: start_addr=0x10, mem[0x10]=0x0005_4002_0001_0000, mem[0x11]=0x8000_8000_C000_0003 -> (0,0), (0,1), (2,5), (2,8).
  - Prefetched words beyond 0x11 are discarded.
  - done fires only after all outstanding responses have arrived.
- Consumer stall: hold index_stall high for 20 cycles mid-stream -> no lost or duplicate pairs, and at most 1 push after stall rises. req stops once FIFO_DEPTH words are held.
- Memory stall: hold req_stall high for 5 cycles -> req stays at 1 with req_addr constant. The address advances by exactly 1 after release.
- Wrap: INDEX_WIDTH=8 instance, codes DELTA 0x00FF then DELTA 0x0002 -> (0,255), (0,1).
- Reset abort: drive rst low during RUN with requests outstanding -> all outputs 0 asynchronously. A new start at 0x20 then decodes correctly from 0x20.
